sound_card: RTL and testbench



---
 rtl/sound_card_pkg.sv | 30 +++
 rtl/sound_card_voice.sv | 47 ++++
 rtl/sound_card.sv | 80 ++++++++
 tb/tb_sound_card.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sound_card_pkg.sv
// Shared constants and types for the four-voice square-wave tone generator.
package sound_card_pkg;

  localparam int NUM_VOICES = 4;
  localparam int CNT_W      = 16;
  localparam int SUM_W      = 10;

  typedef logic [7:0]       sample_t;
  typedef logic [SUM_W-1:0] sum_t;

  // Largest 8-bit sample, used as the clamp ceiling.
  localparam sum_t SAMPLE_MAX = 10'd255;

  // Clamps a wide voice sum into the 8-bit sample range.
  function automatic sample_t clamp_sample(input sum_t s);
    sample_t r;
    if (s > SAMPLE_MAX) begin
      r = 8'hFF;
    end else begin
      r = sample_t'(s);
    end
    return r;
  endfunction

  // Keeps only the low 8 bits of a wide voice sum (modulo-256 wrap).
  function automatic sample_t wrap_sample(input sum_t s);
    return sample_t'(s);
  endfunction

endpackage

// File: rtl/sound_card_voice.sv
// One fixed-pitch square-wave voice: a half-period counter plus a phase bit.
module sound_card_voice
  import sound_card_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic phase
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Next-state: a disabled voice is held at count 0 / phase low so it restarts cleanly.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 16'd1;
      phase_d = phase_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/sound_card.sv
// Four-voice square-wave tone generator with a registered 8-bit mixed sample.
// Optional build macro SOUND_CARD_SATURATE_EN clamps the mix at 255 instead of wrapping.
module sound_card
  import sound_card_pkg::*;
#(
  parameter int HALF0     = 2,
  parameter int HALF1     = 3,
  parameter int HALF2     = 5,
  parameter int HALF3     = 8,
  parameter int AMPLITUDE = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] switches,
  output logic [7:0] combined
);

  localparam sum_t AMP = SUM_W'(AMPLITUDE);

  logic [NUM_VOICES-1:0] phase_s;
  sum_t                  sum_d;
  sample_t               combined_d, combined_q;

  sound_card_voice #(.HALF(HALF0)) u_voice0 (
    .clk   (clk),
    .reset (reset),
    .en    (switches[0]),
    .phase (phase_s[0])
  );

  sound_card_voice #(.HALF(HALF1)) u_voice1 (
    .clk   (clk),
    .reset (reset),
    .en    (switches[1]),
    .phase (phase_s[1])
  );

  sound_card_voice #(.HALF(HALF2)) u_voice2 (
    .clk   (clk),
    .reset (reset),
    .en    (switches[2]),
    .phase (phase_s[2])
  );

  sound_card_voice #(.HALF(HALF3)) u_voice3 (
    .clk   (clk),
    .reset (reset),
    .en    (switches[3]),
    .phase (phase_s[3])
  );

  // Mix: the live switch gates each voice so a disable takes effect on the very next sample.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (switches[i] && phase_s[i]) begin
        sum_d = sum_d + AMP;
      end else begin
        sum_d = sum_d;
      end
    end
`ifdef SOUND_CARD_SATURATE_EN
    combined_d = clamp_sample(sum_d);
`else
    combined_d = wrap_sample(sum_d);
`endif
  end

  // Output sample register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      combined_q <= 8'd0;
    end else begin
      combined_q <= combined_d;
    end
  end

  assign combined = combined_q;

endmodule

// File: tb/tb_sound_card.sv
// Directed self-checking bench for sound_card (default amplitude and a 100-level instance).
module tb_sound_card;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] switches;
  logic [7:0] combined;
  logic [7:0] combined_big;

  int checks   = 0;
  int failures = 0;

  int en_cnt [4];
  int halfs  [4];
  logic [7:0] exp_s;
  logic [7:0] exp_big;
  logic       seen_max;

  always #10 clk = ~clk;

  sound_card #(.AMPLITUDE(63)) dut (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .combined (combined)
  );

  sound_card #(.AMPLITUDE(100)) dut_big (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .combined (combined_big)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One rising edge; the model predicts the sample from the pre-edge enable counts.
  task automatic tick();
    int n;
    int big;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (switches[i] && (((en_cnt[i] / halfs[i]) % 2) == 1)) n++;
    end
    if (reset) n = 0;
    exp_s = 8'(63 * n);
    big   = 100 * n;
`ifdef SOUND_CARD_SATURATE_EN
    exp_big = (big > 255) ? 8'd255 : 8'(big);
`else
    exp_big = 8'(big % 256);
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (reset || !switches[i]) en_cnt[i] = 0;
      else en_cnt[i] = en_cnt[i] + 1;
    end
  endtask

  task automatic tick_model(input string tag);
    tick();
    check(tag, combined, exp_s);
    check({tag, "_big"}, combined_big, exp_big);
  endtask

  initial begin
    logic [7:0] v0_tab [8];
    logic [7:0] re_tab [10];
    logic [7:0] big4, big3;
    v0_tab = '{8'd0, 8'd0, 8'd63, 8'd63, 8'd0, 8'd0, 8'd63, 8'd63};
    re_tab = '{8'd0, 8'd0, 8'd0, 8'd63, 8'd63, 8'd63, 8'd0, 8'd0, 8'd63, 8'd126};
`ifdef SOUND_CARD_SATURATE_EN
    big4 = 8'd255;
    big3 = 8'd255;
`else
    big4 = 8'd144;
    big3 = 8'd44;
`endif
    halfs    = '{2, 3, 5, 8};
    en_cnt   = '{0, 0, 0, 0};
    seen_max = 1'b0;
    reset    = 1'b1;
    switches = 4'b1111;

    // Reset held with all switches on, then the first edge after release.
    repeat (2) begin
      tick();
      check("reset_hold", combined, 8'd0);
      check("reset_hold_big", combined_big, 8'd0);
    end
    reset = 1'b0;
    tick();
    check("reset_release", combined, 8'd0);

    // Voice 0 alone.
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    switches = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("v0_seq", combined, v0_tab[k]);
    end

    // Voice 3 alone, then disable while its phase is high.
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    switches = 4'b1000;
    for (int k = 0; k < 28; k++) begin
      tick();
      check("v3_seq", combined, (((k / 8) % 2) == 1) ? 8'd63 : 8'd0);
    end
    switches = 4'b0000;
    tick();
    check("v3_disable", combined, 8'd0);
    check("v3_disable_big", combined_big, 8'd0);

    // All voices for 240 cycles.
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    switches = 4'b1111;
    for (int m = 1; m <= 240; m++) begin
      tick_model("all_model");
      if (combined == 8'd252) seen_max = 1'b1;
      if (m == 10) begin
        check("three_high", combined, 8'd189);
        check("three_high_big", combined_big, big3);
      end
      if (m == 16) begin
        check("four_high", combined, 8'd252);
        check("four_high_big", combined_big, big4);
      end
    end
    check("max_reached", {7'd0, seen_max}, 8'd1);

    // Mixed patterns, 50 cycles each, then voices 1/3 re-enabled from phase low.
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    switches = 4'b1010;
    repeat (50) tick_model("mix_1010");
    switches = 4'b0101;
    tick_model("mix_0101");
    check("mix_swap_first", combined, 8'd0);
    repeat (49) tick_model("mix_0101");
    switches = 4'b1010;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("reenable_seq", combined, re_tab[k]);
    end

    // Reset mid-tone takes priority.
    reset = 1'b1;
    tick();
    check("reset_midtone", combined, 8'd0);
    check("reset_midtone_big", combined_big, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
